// File: rtl/scratchpad_bb_pkg.sv
// Shared defaults, lane arithmetic and the response record for the scratchpad.
package scratchpad_bb_pkg;

  localparam int SP_DATA_W    = 64;
  localparam int SP_DEPTH     = 1024;
  localparam int SP_TAG_W     = 5;
  localparam int SP_RSP_DEPTH = 2;
  localparam int SP_LANES     = SP_DATA_W / 8;

  typedef struct packed {
    logic [SP_TAG_W-1:0]  tag;
    logic [SP_DATA_W-1:0] data;
  } resp_t;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/scratchpad_bb_if.sv
// Request/response handshake bundle between the accelerator datapath and the scratchpad.
interface scratchpad_bb_if
  import scratchpad_bb_pkg::*;
#(
  parameter int DATA_W = SP_DATA_W,
  parameter int ADDR_W = $clog2(SP_DEPTH),
  parameter int TAG_W  = SP_TAG_W
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [TAG_W-1:0]      req_tag;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [TAG_W-1:0]      resp_tag;
  logic [DATA_W-1:0]     resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_tag, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_tag, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_tag, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_tag, resp_data
  );
endinterface

// File: rtl/scratchpad_bb_chk.sv
// Simulation checks on the response FIFO occupancy.
module scratchpad_bb_chk (
  input logic clock,
  input logic reset_n,
  input logic push,
  input logic pop,
  input logic empty,
  input logic full
);
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && full));

  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop && empty));
endmodule

// File: rtl/scratchpad_bb_resp_fifo.sv
// Small synchronous FIFO holding read responses the consumer has not yet taken.
module scratchpad_bb_resp_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (32'(p) == DEPTH - 1) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      store_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = store_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {CNT_W{1'b0}});
  assign full  = (count_r == CNT_W'(DEPTH));
endmodule

// File: rtl/scratchpad_bb.sv
// Single-port scratchpad: byte-masked writes, one-cycle reads into s1, and a
// fall-through response FIFO guarded by a credit check on req_ready.
module scratchpad_bb
  import scratchpad_bb_pkg::*;
#(
  parameter int DATA_W    = SP_DATA_W,
  parameter int DEPTH     = SP_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int TAG_W     = SP_TAG_W,
  parameter int RSP_DEPTH = SP_RSP_DEPTH
) (
  input logic            clock,
  input logic            reset_n,
  scratchpad_bb_if.slave bus
);
  localparam int LANES = lane_count(DATA_W);
  localparam int ENT_W = TAG_W + DATA_W;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              s1_valid_r;
  logic [TAG_W-1:0]  s1_tag_r;
  logic [DATA_W-1:0] s1_data_r;

  logic              fire_s;
  logic              rd_fire_s;
  logic              wr_fire_s;
  logic              addr_ok_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [ENT_W-1:0]  fifo_head_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [CNT_W:0]    credit_used_s;

  generate
    if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
      assign addr_ok_s = 1'b1;
    end else begin : g_partial_range
      assign addr_ok_s = (32'(bus.req_addr) < 32'(DEPTH));
    end
  endgenerate

  // Every response not yet taken (queued or in s1) holds one FIFO slot in reserve.
  assign credit_used_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, s1_valid_r};
  assign bus.req_ready = (credit_used_s < (CNT_W + 1)'(RSP_DEPTH));

  assign fire_s    = bus.req_valid && bus.req_ready;
  assign wr_fire_s = fire_s && bus.req_write;
  assign rd_fire_s = fire_s && !bus.req_write;

  // Byte-lane masked write; out-of-range addresses are dropped.
  always_ff @(posedge clock) begin
    if (wr_fire_s && addr_ok_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.req_wmask[i]) begin
          mem_r[bus.req_addr][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read stage: memory sampled at the accept edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_tag_r   <= {TAG_W{1'b0}};
      s1_data_r  <= {DATA_W{1'b0}};
    end else begin
      s1_valid_r <= rd_fire_s;
      if (rd_fire_s) begin
        s1_tag_r  <= bus.req_tag;
        s1_data_r <= addr_ok_s ? mem_r[bus.req_addr] : {DATA_W{1'b0}};
      end
    end
  end

  // s1 bypasses the FIFO only when nothing older is queued and the consumer takes it now.
  assign fifo_push_s = s1_valid_r && (!fifo_empty_s || !bus.resp_ready);
  assign fifo_pop_s  = !fifo_empty_s && bus.resp_ready;

  scratchpad_bb_resp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push_s),
    .push_data ({s1_tag_r, s1_data_r}),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  scratchpad_bb_chk u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push_s),
    .pop     (fifo_pop_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  assign bus.resp_valid = s1_valid_r || !fifo_empty_s;
  assign {bus.resp_tag, bus.resp_data} = fifo_empty_s ? {s1_tag_r, s1_data_r} : fifo_head_s;
endmodule

// File: tb/tb_scratchpad_bb.sv
// Directed and model-checked bench for scratchpad_bb at the default configuration.
module tb_scratchpad_bb;
  import scratchpad_bb_pkg::*;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int TW = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  scratchpad_bb_if #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) bus ();

  scratchpad_bb #(
    .DATA_W(DW), .DEPTH(1024), .ADDR_W(AW), .TAG_W(TW), .RSP_DEPTH(2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    logic        w;
    logic [9:0]  a;
    logic [4:0]  t;
    logic [63:0] d;
    logic [7:0]  m;
    logic        ev;
    logic [4:0]  et;
    logic [63:0] ed;
  } vec_t;

  vec_t        vt[11];
  logic [63:0] mm[16];
  resp_t       q[$];
  resp_t       exp_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [9:0] a, input logic [4:0] t,
                       input logic [63:0] d, input logic [7:0] m);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_tag   = t;
    bus.req_wdata = d;
    bus.req_wmask = m;
  endtask

  initial begin
    logic v, w, rr, exp_rdy;
    logic [9:0] a;
    logic [4:0] t;
    logic [63:0] d;
    logic [7:0] m;

    vt[0]  = '{1'b1, 1'b1, 10'd5, 5'd0,  64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0, 5'd0,  64'h0};
    vt[1]  = '{1'b1, 1'b0, 10'd5, 5'd3,  64'h0,                 8'h00, 1'b0, 5'd0,  64'h0};
    vt[2]  = '{1'b1, 1'b1, 10'd7, 5'd0,  64'h11111111_11111111, 8'hFF, 1'b1, 5'd3,  64'hDEADBEEF_CAFEF00D};
    vt[3]  = '{1'b1, 1'b1, 10'd7, 5'd0,  64'hAAAAAAAA_AAAAAAAA, 8'h0F, 1'b0, 5'd0,  64'h0};
    vt[4]  = '{1'b1, 1'b0, 10'd7, 5'd9,  64'h0,                 8'h00, 1'b0, 5'd0,  64'h0};
    vt[5]  = '{1'b1, 1'b1, 10'd0, 5'd0,  64'h01234567_89ABCDEF, 8'hFF, 1'b1, 5'd9,  64'h11111111_AAAAAAAA};
    vt[6]  = '{1'b1, 1'b1, 10'd0, 5'd0,  64'hFFFFFFFF_FFFFFFFF, 8'h81, 1'b0, 5'd0,  64'h0};
    vt[7]  = '{1'b1, 1'b0, 10'd0, 5'd31, 64'h0,                 8'h00, 1'b0, 5'd0,  64'h0};
    vt[8]  = '{1'b1, 1'b0, 10'd5, 5'd0,  64'h0,                 8'h00, 1'b1, 5'd31, 64'hFF234567_89ABCDFF};
    vt[9]  = '{1'b0, 1'b0, 10'd0, 5'd0,  64'h0,                 8'h00, 1'b1, 5'd0,  64'hDEADBEEF_CAFEF00D};
    vt[10] = '{1'b0, 1'b0, 10'd0, 5'd0,  64'h0,                 8'h00, 1'b0, 5'd0,  64'h0};

    // Reset values
    drive(1'b0, 1'b0, 10'd0, 5'd0, 64'h0, 8'h00);
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_req_ready",  64'(bus.req_ready),  64'd1);
    check("rst_resp_tag",   64'(bus.resp_tag),   64'd0);
    check("rst_resp_data",  bus.resp_data,       64'd0);
    reset_n = 1'b1;

    // Table: one op per cycle, outputs expected from the previous op
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      drive(vt[i].v, vt[i].w, vt[i].a, vt[i].t, vt[i].d, vt[i].m);
      #1;
      check($sformatf("vec%0d_req_ready", i),  64'(bus.req_ready),  64'd1);
      check($sformatf("vec%0d_resp_valid", i), 64'(bus.resp_valid), 64'(vt[i].ev));
      if (vt[i].ev) begin
        check($sformatf("vec%0d_resp_tag", i),  64'(bus.resp_tag), 64'(vt[i].et));
        check($sformatf("vec%0d_resp_data", i), bus.resp_data,     vt[i].ed);
      end
    end

    // Backpressure: two reads fill the credits, then drain in order
    @(negedge clock);
    bus.resp_ready = 1'b0;
    drive(1'b1, 1'b0, 10'd5, 5'd1, 64'h0, 8'h00);
    #1 check("bp_ready0", 64'(bus.req_ready), 64'd1);
    @(negedge clock);
    drive(1'b1, 1'b0, 10'd7, 5'd2, 64'h0, 8'h00);
    #1 check("bp_ready1", 64'(bus.req_ready), 64'd1);
    check("bp_tag_a", 64'(bus.resp_tag), 64'd1);
    @(negedge clock);
    drive(1'b1, 1'b0, 10'd0, 5'd4, 64'h0, 8'h00);
    #1 check("bp_ready2", 64'(bus.req_ready), 64'd0);
    check("bp_valid2", 64'(bus.resp_valid), 64'd1);
    @(negedge clock);
    #1 check("bp_ready3", 64'(bus.req_ready), 64'd0);
    check("bp_hold_tag",  64'(bus.resp_tag), 64'd1);
    check("bp_hold_data", bus.resp_data,     64'hDEADBEEF_CAFEF00D);
    drive(1'b0, 1'b0, 10'd0, 5'd0, 64'h0, 8'h00);
    bus.resp_ready = 1'b1;
    @(negedge clock);
    #1 check("bp_out2_tag",  64'(bus.resp_tag), 64'd2);
    check("bp_out2_data", bus.resp_data, 64'h11111111_AAAAAAAA);
    @(negedge clock);
    #1 check("bp_empty_valid", 64'(bus.resp_valid), 64'd0);
    check("bp_empty_ready", 64'(bus.req_ready), 64'd1);

    // Back-to-back: fill @0..15, then 16 consecutive reads
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      mm[k] = 64'hC0DE_0000_0000_0000 | 64'(k);
      drive(1'b1, 1'b1, 10'(k), 5'd0, mm[k], 8'hFF);
    end
    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      if (k < 16) drive(1'b1, 1'b0, 10'(k), 5'(k), 64'h0, 8'h00);
      else        drive(1'b0, 1'b0, 10'd0, 5'd0, 64'h0, 8'h00);
      #1 check($sformatf("b2b%0d_ready", k), 64'(bus.req_ready), 64'd1);
      if (k > 0) begin
        check($sformatf("b2b%0d_valid", k), 64'(bus.resp_valid), 64'd1);
        check($sformatf("b2b%0d_tag", k),   64'(bus.resp_tag),   64'(5'(k - 1)));
        check($sformatf("b2b%0d_data", k),  bus.resp_data,       mm[k - 1]);
      end
    end

    // Random mixed traffic against a reference model
    for (int n = 0; n < 1000; n++) begin
      @(negedge clock);
      v  = ($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      a  = 10'($urandom_range(0, 15));
      t  = 5'($urandom_range(0, 31));
      d  = {$urandom, $urandom};
      m  = 8'($urandom_range(0, 255));
      rr = 1'($urandom_range(0, 1));
      drive(v, w, a, t, d, m);
      bus.resp_ready = rr;
      #1;
      exp_rdy = (q.size() < 2);
      check("rnd_req_ready",  64'(bus.req_ready),  64'(exp_rdy));
      check("rnd_resp_valid", 64'(bus.resp_valid), 64'(q.size() != 0));
      if (q.size() != 0 && rr) begin
        exp_r = q.pop_front();
        check("rnd_resp_tag",  64'(bus.resp_tag), 64'(exp_r.tag));
        check("rnd_resp_data", bus.resp_data,     exp_r.data);
      end
      if (v && exp_rdy) begin
        if (w) begin
          for (int b = 0; b < 8; b++) begin
            if (m[b]) mm[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
          end
        end else begin
          q.push_back('{tag: t, data: mm[a[3:0]]});
        end
      end
    end
    drive(1'b0, 1'b0, 10'd0, 5'd0, 64'h0, 8'h00);
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 4 && q.size() != 0; k++) begin
      @(negedge clock);
      #1 check("drain_valid", 64'(bus.resp_valid), 64'd1);
      exp_r = q.pop_front();
      check("drain_tag",  64'(bus.resp_tag), 64'(exp_r.tag));
      check("drain_data", bus.resp_data,     exp_r.data);
    end
    check("drain_empty", 64'(q.size()), 64'd0);

    // Reset with two queued responses
    @(negedge clock);
    bus.resp_ready = 1'b0;
    drive(1'b1, 1'b0, 10'd3, 5'd5, 64'h0, 8'h00);
    @(negedge clock);
    drive(1'b1, 1'b0, 10'd4, 5'd6, 64'h0, 8'h00);
    @(negedge clock);
    drive(1'b0, 1'b0, 10'd0, 5'd0, 64'h0, 8'h00);
    #1 check("rq_full_ready", 64'(bus.req_ready), 64'd0);
    check("rq_head_tag", 64'(bus.resp_tag), 64'd5);
    check("rq_head_data", bus.resp_data, mm[3]);
    @(negedge clock);
    reset_n = 1'b0;
    #1 check("rq_rst_valid", 64'(bus.resp_valid), 64'd0);
    check("rq_rst_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    bus.resp_ready = 1'b1;
    drive(1'b1, 1'b0, 10'd3, 5'd7, 64'h0, 8'h00);
    @(negedge clock);
    drive(1'b0, 1'b0, 10'd0, 5'd0, 64'h0, 8'h00);
    #1 check("rq_post_valid", 64'(bus.resp_valid), 64'd1);
    check("rq_post_tag",  64'(bus.resp_tag), 64'd7);
    check("rq_post_data", bus.resp_data,     mm[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
